// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C request arbiter.
// Holds the arbiter FSM state encoding, the command field widths and the
// default watchdog limit.
package i2c_arb_pkg;

    localparam int unsigned ADDR_W          = 7;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned NBYTE_W         = 4;
    localparam int unsigned WD_W            = 16;
    localparam int unsigned TIMEOUT_CYC_DEF = 65535;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StActive,
        StDone
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Ports:
//   req_i   - request vector
//   last_i  - index of the previous owner; search starts one above it
//   win_o   - one-hot winner (all zero when no request)
//   idx_o   - binary index of the winner
//   valid_o - at least one request present
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdxW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [NREQ-1:0] win_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        win_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Walk last+1, last+2, ... wrapping; the previous owner is tried last.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand     = (32'(last_i) + k) % NREQ;
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
        if (valid_o) begin
            win_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ requesters.
// The winner's command is latched at grant time and held on the master's
// command inputs until the transaction completes.
// Ports:
//   clk_i, resetN_i          - clock, asynchronous active-low reset
//   req_i/req_addr_i/req_rw_i/req_data_i/req_nbyte_i - per-requester command
//   m_busy_i                 - master out of idle
//   gnt_o                    - one-hot grant held for the transaction
//   done_o                   - one-cycle completion pulse to the owner
//   m_en_o, m_rw_o, m_address_o, m_data_in_o, m_n_byte_o - master command
//   timeout_o                - one-cycle watchdog abort pulse
// Build option: define I2C_ARB_TIMEOUT_EN to include the watchdog; otherwise
// timeout_o is tied low and the FSM waits indefinitely on m_busy_i.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                    clk_i,
    input  logic                    resetN_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*ADDR_W-1:0]  req_addr_i,
    input  logic [NREQ-1:0]         req_rw_i,
    input  logic [NREQ*DATA_W-1:0]  req_data_i,
    input  logic [NREQ*NBYTE_W-1:0] req_nbyte_i,
    input  logic                    m_busy_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [NREQ-1:0]         done_o,
    output logic                    m_en_o,
    output logic                    m_rw_o,
    output logic [ADDR_W-1:0]       m_address_o,
    output logic [DATA_W-1:0]       m_data_in_o,
    output logic [NBYTE_W-1:0]      m_n_byte_o,
    output logic                    timeout_o
);

    localparam int unsigned IdxW = $clog2(NREQ);

    arb_state_e          state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                m_en_q, m_en_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NBYTE_W-1:0]  nbyte_q, nbyte_d;
    logic [IdxW-1:0]     own_q, own_d;
    logic [IdxW-1:0]     last_q, last_d;

    logic [NREQ-1:0]     win;
    logic [IdxW-1:0]     win_idx;
    logic                win_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NBYTE_W-1:0]  sel_nbyte;
    logic                sel_rw;

    rr_pick #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .win_o   (win),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // Command mux for the current round-robin winner.
    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        sel_nbyte = '0;
        sel_rw    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IdxW'(i)) begin
                sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_data  = req_data_i[i*DATA_W +: DATA_W];
                sel_nbyte = req_nbyte_i[i*NBYTE_W +: NBYTE_W];
                sel_rw    = req_rw_i[i];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    logic            wd_hit;

    assign wd_hit = ((state_q == StLaunch) || (state_q == StActive)) &&
                    (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        m_en_d  = m_en_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        nbyte_d = nbyte_q;
        own_d   = own_q;
        last_d  = last_q;

        unique case (state_q)
            StIdle: begin
                // A busy master here belongs to someone else; hold off.
                if (win_valid && !m_busy_i) begin
                    gnt_d   = win;
                    own_d   = win_idx;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    nbyte_d = sel_nbyte;
                    rw_d    = sel_rw;
                    m_en_d  = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                if (m_busy_i) begin
                    m_en_d  = 1'b0;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (!m_busy_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                gnt_d   = '0;
                last_d  = own_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef I2C_ARB_TIMEOUT_EN
        to_d = 1'b0;
        wd_d = ((state_q == StLaunch) || (state_q == StActive)) ? wd_q + 1'b1 : '0;
        if (wd_hit) begin
            m_en_d  = 1'b0;
            to_d    = 1'b1;
            state_d = StDone;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            m_en_q  <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            nbyte_q <= '0;
            own_q   <= '0;
            last_q  <= IdxW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            m_en_q  <= m_en_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            nbyte_q <= nbyte_d;
            own_q   <= own_d;
            last_q  <= last_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_o = to_q;
`else
    assign timeout_o = 1'b0;
`endif

    // done coincides with the single DONE cycle, while gnt still names the owner.
    assign done_o      = (state_q == StDone) ? gnt_q : '0;
    assign gnt_o       = gnt_q;
    assign m_en_o      = m_en_q;
    assign m_rw_o      = rw_q;
    assign m_address_o = addr_q;
    assign m_data_in_o = data_q;
    assign m_n_byte_o  = nbyte_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed self-checking bench for i2c_req_arbiter (NREQ=4, TIMEOUT_CYC=100).
module tb_i2c_req_arbiter;

    logic        clk;
    logic        resetN;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [3:0]  req_rw;
    logic [31:0] req_data;
    logic [15:0] req_nbyte;
    logic        m_busy;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        m_en;
    logic        m_rw;
    logic [6:0]  m_address;
    logic [7:0]  m_data_in;
    logic [3:0]  m_n_byte;
    logic        timeout;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    i2c_req_arbiter #(
        .NREQ        (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk_i       (clk),
        .resetN_i    (resetN),
        .req_i       (req),
        .req_addr_i  (req_addr),
        .req_rw_i    (req_rw),
        .req_data_i  (req_data),
        .req_nbyte_i (req_nbyte),
        .m_busy_i    (m_busy),
        .gnt_o       (gnt),
        .done_o      (done),
        .m_en_o      (m_en),
        .m_rw_o      (m_rw),
        .m_address_o (m_address),
        .m_data_in_o (m_data_in),
        .m_n_byte_o  (m_n_byte),
        .timeout_o   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_time_limit: observed running expected finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " gnt"}, 32'(gnt), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " m_en"}, 32'(m_en), 0);
        chk({tag, " m_rw"}, 32'(m_rw), 0);
        chk({tag, " m_address"}, 32'(m_address), 0);
        chk({tag, " m_data_in"}, 32'(m_data_in), 0);
        chk({tag, " m_n_byte"}, 32'(m_n_byte), 0);
        chk({tag, " timeout"}, 32'(timeout), 0);
    endtask

    // Grant expected on the next edge; short busy window; checks done and release.
    task automatic serve(input string tag, input logic [3:0] exp_gnt, input logic [6:0] exp_addr);
        tick();
        chk({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, " m_en"}, 32'(m_en), 1);
        chk({tag, " addr"}, 32'(m_address), 32'(exp_addr));
        m_busy = 1'b1;
        tick();
        chk({tag, " m_en_low"}, 32'(m_en), 0);
        repeat (3) tick();
        m_busy = 1'b0;
        tick();
        chk({tag, " done"}, 32'(done), 32'(exp_gnt));
        chk({tag, " timeout"}, 32'(timeout), 0);
        tick();
        chk({tag, " gnt_clear"}, 32'(gnt), 0);
        chk({tag, " done_clear"}, 32'(done), 0);
    endtask

    logic [3:0] done_seen;

    initial begin
        resetN    = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_rw    = '0;
        req_data  = '0;
        req_nbyte = '0;
        m_busy    = 1'b0;
        tick();
        all_zero("reset");
        resetN = 1'b1;
        tick();
        all_zero("idle_after_reset");

        // Single request from slot 0
        req_addr[6:0]   = 7'h50;
        req_rw[0]       = 1'b0;
        req_data[7:0]   = 8'hA5;
        req_nbyte[3:0]  = 4'd2;
        req             = 4'b0001;
        tick();
        chk("single gnt", 32'(gnt), 32'h1);
        chk("single m_en", 32'(m_en), 1);
        chk("single addr", 32'(m_address), 32'h50);
        chk("single data", 32'(m_data_in), 32'hA5);
        chk("single nbyte", 32'(m_n_byte), 2);
        chk("single rw", 32'(m_rw), 0);
        req = 4'b0000;
        tick();
        tick();
        chk("single m_en_held", 32'(m_en), 1);
        m_busy = 1'b1;
        tick();
        chk("single m_en_low", 32'(m_en), 0);
        done_seen = '0;
        for (int i = 0; i < 39; i++) begin
            tick();
            done_seen = done_seen | done;
        end
        chk("single no_early_done", 32'(done_seen), 0);
        m_busy = 1'b0;
        tick();
        chk("single done", 32'(done), 32'h1);
        tick();
        chk("single done_once", 32'(done), 0);
        chk("single gnt_clear", 32'(gnt), 0);

        // Round robin from a fresh reset with all four requesting
        resetN = 1'b0;
        tick();
        resetN   = 1'b1;
        req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
        req      = 4'b1111;
        serve("rr0", 4'b0001, 7'h10);
        serve("rr1", 4'b0010, 7'h11);
        serve("rr2", 4'b0100, 7'h12);
        serve("rr3", 4'b1000, 7'h13);
        serve("rr4", 4'b0001, 7'h10);
        req = 4'b0000;

        // Request drop from slot 2 during ACTIVE; zero byte count passes through
        req_addr[20:14]  = 7'h2A;
        req_rw[2]        = 1'b1;
        req_data[23:16]  = 8'h3C;
        req_nbyte[11:8]  = 4'd0;
        req              = 4'b0100;
        tick();
        chk("drop gnt", 32'(gnt), 32'h4);
        chk("drop nbyte0", 32'(m_n_byte), 0);
        m_busy = 1'b1;
        tick();
        req       = 4'b0000;
        req_addr  = '1;
        req_rw    = '0;
        req_data  = '1;
        req_nbyte = '1;
        repeat (4) tick();
        chk("drop addr_stable", 32'(m_address), 32'h2A);
        chk("drop rw_stable", 32'(m_rw), 1);
        chk("drop data_stable", 32'(m_data_in), 32'h3C);
        chk("drop nbyte_stable", 32'(m_n_byte), 0);
        chk("drop gnt_held", 32'(gnt), 32'h4);
        m_busy = 1'b0;
        tick();
        chk("drop done", 32'(done), 32'h4);
        chk("drop addr_in_done", 32'(m_address), 32'h2A);
        tick();

        // Busy blocking in IDLE
        m_busy = 1'b1;
        req    = 4'b0010;
        repeat (3) tick();
        chk("busyblk no_gnt", 32'(gnt), 0);
        m_busy = 1'b0;
        tick();
        chk("busyblk gnt", 32'(gnt), 32'h2);
        m_busy = 1'b1;
        tick();
        req    = 4'b0000;
        m_busy = 1'b0;
        tick();
        chk("busyblk done", 32'(done), 32'h2);
        tick();

        // Reset while ACTIVE
        req = 4'b1000;
        tick();
        chk("rstact gnt", 32'(gnt), 32'h8);
        m_busy = 1'b1;
        tick();
        req    = 4'b0000;
        resetN = 1'b0;
        #1;
        all_zero("rstact async");
        m_busy = 1'b0;
        tick();
        resetN    = 1'b1;
        done_seen = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            done_seen = done_seen | done;
        end
        chk("rstact no_done", 32'(done_seen), 0);
        req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
        req      = 4'b1111;
        serve("rstact slot0", 4'b0001, 7'h10);
        req = 4'b0000;
        tick();

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog: m_busy stuck high after the grant
        req = 4'b0010;
        tick();
        chk("wd gnt", 32'(gnt), 32'h2);
        m_busy = 1'b1;
        done_seen = '0;
        for (int i = 0; i < 99; i++) begin
            tick();
            done_seen = done_seen | done | {3'b000, timeout};
        end
        chk("wd no_early", 32'(done_seen), 0);
        tick();
        chk("wd timeout", 32'(timeout), 1);
        chk("wd done", 32'(done), 32'h2);
        chk("wd m_en", 32'(m_en), 0);
        tick();
        chk("wd timeout_pulse", 32'(timeout), 0);
        chk("wd gnt_clear", 32'(gnt), 0);
        repeat (3) tick();
        chk("wd no_regrant", 32'(gnt), 0);
        m_busy = 1'b0;
        req    = 4'b0000;
        tick();
`else
        // Without the watchdog a stuck m_busy keeps the grant and never times out
        req = 4'b0010;
        tick();
        chk("nowd gnt", 32'(gnt), 32'h2);
        m_busy    = 1'b1;
        req       = 4'b0000;
        done_seen = '0;
        for (int i = 0; i < 150; i++) begin
            tick();
            done_seen = done_seen | done | {3'b000, timeout};
        end
        chk("nowd quiet", 32'(done_seen), 0);
        chk("nowd gnt_held", 32'(gnt), 32'h2);
        m_busy = 1'b0;
        tick();
        chk("nowd done", 32'(done), 32'h2);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 65535, SHALL set the watchdog limit in clk cycles (16-bit).
REQ-003 clk  in  1  SHALL be the single system clock; all state updates on rising edge.
REQ-004 resetN  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  in  NREQ  SHALL carry the per-requester transaction request level.
REQ-006 req_addr  in  NREQ*7  SHALL carry the per-requester 7-bit slave address; slot i at bits [7i+6:7i].
REQ-007 req_rw  in  NREQ  SHALL carry the per-requester direction; 1 = read.
REQ-008 req_data  in  NREQ*8  SHALL carry the per-requester write byte.
REQ-009 req_nbyte  in  NREQ*4  SHALL carry the per-requester byte count.
REQ-010 m_busy  in  1  SHALL be high while the I2C master FSM is out of idle.
REQ-011 gnt  out  NREQ  SHALL be the one-hot grant, held for the whole transaction.
REQ-012 done  out  NREQ  SHALL be a one-cycle completion pulse to the owner.
REQ-013 m_en, m_rw  out  1 each; m_address  out 7; m_data_in  out 8; m_n_byte  out 4  SHALL drive the master's command inputs.
REQ-014 timeout  out  1  SHALL be a one-cycle abort pulse; tied 0 without the macro.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH, ACTIVE and DONE.
REQ-016 IDLE: when any req bit is high and m_busy is low, the FSM SHALL pick one winner, latch its addr/rw/data/nbyte, set gnt and go to LAUNCH.
- Latency: req high at cycle n → gnt and m_en high at cycle n+1.
REQ-017 Arbitration SHALL be round-robin.
- Search starts at (last_owner+1) mod NREQ.
- last_owner resets to NREQ-1, so slot 0 wins first.
REQ-018 LAUNCH: m_en SHALL be held high until m_busy is sampled high, then go to ACTIVE with m_en low.
REQ-019 ACTIVE: on m_busy sampled low, the FSM SHALL go to DONE.
REQ-020 DONE: the owner's done bit SHALL pulse for one cycle, gnt SHALL clear, last_owner SHALL update, and the FSM SHALL return to IDLE.
- Back-to-back grants are therefore separated by at least one IDLE cycle.
REQ-021 m_address/m_rw/m_data_in/m_n_byte SHALL come from the latched registers and stay stable from LAUNCH through DONE.
- Requester input changes after the grant SHALL be ignored.
REQ-022 A req drop after the grant SHALL NOT abort the transaction; the owner still receives done.
REQ-023 A new req from the current owner SHALL compete only in the next IDLE, at lowest priority.
REQ-024 If m_busy is high in IDLE (foreign or aborted transaction), no grant SHALL issue until m_busy is low.
REQ-025 req_nbyte = 0 SHALL still be passed through unmodified; range checking belongs to the master.

Reset
REQ-026 On resetN low, asynchronously:
- FSM → IDLE.
- gnt, done, m_en, timeout, m_rw → 0; m_address, m_data_in, m_n_byte → 0.
- last_owner → NREQ-1; watchdog → 0.
REQ-027 Reset mid-transaction SHALL drop the grant with no done pulse.

Configuration
REQ-028 With I2C_ARB_TIMEOUT_EN defined, a 16-bit watchdog SHALL behave as follows:
- Counts every cycle in LAUNCH/ACTIVE; clears in IDLE.
- On reaching TIMEOUT_CYC: force m_en low, pulse timeout and done together, go to DONE.
REQ-029 Without I2C_ARB_TIMEOUT_EN, the watchdog logic SHALL be absent, timeout SHALL be constant 0, and the FSM SHALL wait indefinitely.

Structure
REQ-030 Package i2c_arb_pkg SHALL hold:
- the state enum (IDLE/LAUNCH/ACTIVE/DONE);
- width constants ADDR_W=7, DATA_W=8, NBYTE_W=4;
- the default TIMEOUT_CYC.
REQ-031 Sub-module rr_pick SHALL hold the combinational round-robin priority pick: req vector plus last_owner in, one-hot winner plus index out.

Verification
REQ-032 Single request:
- Stimulus: req=0001, addr 0x50, rw=0, data 0xA5, nbyte 2; m_busy high 3 cycles after m_en, low 40 cycles later.
- Response: gnt=0001 at n+1; m_address=0x50; one done[0] pulse one cycle after m_busy falls.
REQ-033 Round-robin:
- Stimulus: req=1111 held continuously.
- Response: grant order 0,1,2,3,0; each pair separated by one IDLE cycle.
REQ-034 Request drop:
- Stimulus: req[2] drops during ACTIVE.
- Response: transaction completes; done[2] still pulses; m_* unchanged throughout.
REQ-035 Busy blocking:
- Stimulus: m_busy high in IDLE with req=0010.
- Response: no gnt until m_busy low; gnt=0010 the next cycle.
REQ-036 Watchdog (macro on, TIMEOUT_CYC=100):
- Stimulus: m_busy stuck high after grant.
- Response: at cycle 100, timeout and done pulse together; m_en=0; no new grant while m_busy is high.
REQ-037 Reset in ACTIVE:
- Stimulus: resetN pulsed low during ACTIVE.
- Response: all outputs 0 immediately; no done pulse; next grant goes to slot 0.
